// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter that lets NUM_MASTERS Wishbone masters
// share one slave port. A master keeps the bus for its whole cyc tenure.
// A watchdog aborts any strobe that the slave leaves unacknowledged.
//
// Handshake: a transfer is offered while cyc and stb are both high. It
// completes in the cycle where the slave raises ack. The master must hold
// adr/dat/we stable until that ack. A master that has not been granted sees
// no ack and keeps holding its request.
`timescale 1ns/1ps
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
    output logic [DATA_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_W-1:0]             s_adr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    input  logic [DATA_W-1:0]             s_dat_i,
    input  logic                          s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          busy_o
);

    localparam int          IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       w_last_nxt;
    logic [15:0]            r_wdog;
    logic [15:0]            w_wdog_nxt;
    logic [NUM_MASTERS-1:0] r_err;
    logic [NUM_MASTERS-1:0] w_err_nxt;

    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_sel_found;
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_g_we;
    logic [ADDR_W-1:0]      w_g_adr;
    logic [DATA_W-1:0]      w_g_dat;
    logic                   w_timeout;

    // Pick the first requester found by searching upward from last+1 with wrap.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_last;
        w_cand      = r_last;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = IDX_W'((int'(r_last) + i) % NUM_MASTERS);
            if (!w_sel_found && m_cyc_i[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    // r_last always holds the index of the current owner while BUS/ABORT.
    assign w_g_cyc = m_cyc_i[r_last];
    assign w_g_stb = m_stb_i[r_last];
    assign w_g_we  = m_we_i[r_last];
    assign w_g_adr = m_adr_i[int'(r_last)*ADDR_W +: ADDR_W];
    assign w_g_dat = m_dat_i[int'(r_last)*DATA_W +: DATA_W];

    // Slave port and acks follow the owner only in BUS; IDLE and ABORT park everything at 0.
    always_comb begin
        m_dat_o = s_dat_i;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (r_state == ST_BUS) begin
            s_cyc_o = w_g_cyc;
            s_stb_o = w_g_stb;
            s_we_o  = w_g_we;
            s_adr_o = w_g_adr;
            s_dat_o = w_g_dat;
            m_ack_o = r_grant & {NUM_MASTERS{s_ack_i & w_g_stb}};
        end
    end

    // Watchdog counts consecutive unacknowledged strobe cycles; an ack in the last cycle wins.
    always_comb begin
        w_timeout = (r_state == ST_BUS) && s_stb_o && !s_ack_i && (r_wdog == TO_LAST);
        if ((r_state == ST_IDLE) || !s_stb_o || s_ack_i) begin
            w_wdog_nxt = '0;
        end else begin
            w_wdog_nxt = r_wdog + 16'd1;
        end
    end

    // Next-state logic: grant in IDLE, release on cyc low, abort on timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_err_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ST_BUS;
                    w_grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_sel_idx;
                    w_last_nxt  = w_sel_idx;
                end
            end
            ST_BUS: begin
                if (!w_g_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT;
                    w_err_nxt   = r_grant;
                end
            end
            ST_ABORT: begin
                if (!w_g_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer, watchdog and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_MASTERS - 1);
            r_wdog  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign grant_o = r_grant;
    assign m_err_o = r_err;
    assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter: directed scenarios plus randomized masters and
// slave, checked every cycle against a tenure-level reference model.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o, busy_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner = index holding the bus (-1: nobody); aborted = owner timed out.
  int           mdl_owner;
  int           mdl_last;
  int           mdl_waited;
  bit           mdl_abort;
  logic [N-1:0] mdl_err;

  // Observations of the last checked cycle, for directed checks.
  logic [N-1:0]  obs_grant, obs_ack, obs_err;
  logic          obs_cyc, obs_stb, obs_busy;
  logic [AW-1:0] obs_adr;
  logic [DW-1:0] obs_sdat, obs_mdat;

  // Scoreboard of tenure starts seen on grant_o, plus idle-gap lengths.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] obs_q[$];
  int           gap_q[$];
  logic [N-1:0] prev_grant;
  int           idle_run;
  logic [N-1:0] prev_ack, prev_err;

  function automatic logic mdl_stb();
    if (mdl_owner >= 0 && !mdl_abort) return m_stb[mdl_owner];
    return 1'b0;
  endfunction

  task automatic mdl_reset();
    mdl_owner  = -1;
    mdl_last   = N - 1;
    mdl_waited = 0;
    mdl_abort  = 1'b0;
    mdl_err    = '0;
    prev_grant = '0;
    idle_run   = 0;
    prev_ack   = '0;
    prev_err   = '0;
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic run_cycle();
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [N-1:0]  e_ack, e_grant, n_err;
    int            n_owner, n_last, n_waited;
    bit            n_abort, found;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    e_ack = '0; e_grant = '0;
    if (mdl_owner >= 0) begin
      e_grant[mdl_owner] = 1'b1;
      if (!mdl_abort) begin
        e_cyc = m_cyc[mdl_owner];
        e_stb = m_stb[mdl_owner];
        e_we  = m_we[mdl_owner];
        e_adr = m_adr[mdl_owner*AW +: AW];
        e_dat = m_dat[mdl_owner*DW +: DW];
        e_ack[mdl_owner] = s_ack & e_stb;
      end
    end
    #1;
    chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
    chk("s_stb", 64'(s_stb_o), 64'(e_stb));
    chk("s_we", 64'(s_we_o), 64'(e_we));
    chk("s_adr", 64'(s_adr_o), 64'(e_adr));
    chk("s_dat", 64'(s_dat_o), 64'(e_dat));
    chk("m_ack", 64'(m_ack_o), 64'(e_ack));
    chk("m_err", 64'(m_err_o), 64'(mdl_err));
    chk("grant", 64'(grant_o), 64'(e_grant));
    chk("busy", 64'(busy_o), 64'(mdl_owner >= 0));
    chk("m_dat", 64'(m_dat_o), 64'(s_dat));
    obs_grant = grant_o; obs_ack = m_ack_o; obs_err = m_err_o;
    obs_cyc = s_cyc_o; obs_stb = s_stb_o; obs_busy = busy_o;
    obs_adr = s_adr_o; obs_sdat = s_dat_o; obs_mdat = m_dat_o;
    if (grant_o != '0 && prev_grant == '0) begin
      obs_q.push_back(grant_o);
      gap_q.push_back(idle_run);
    end
    idle_run   = (grant_o == '0) ? idle_run + 1 : 0;
    prev_grant = grant_o;
    prev_ack   = e_ack;
    prev_err   = mdl_err;
    // model next state
    n_owner = mdl_owner; n_last = mdl_last; n_waited = mdl_waited;
    n_abort = mdl_abort; n_err = '0; found = 1'b0;
    if (mdl_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (mdl_last + i) % N;
        if (!found && m_cyc[c]) begin
          found = 1'b1; n_owner = c; n_last = c; n_waited = 0;
        end
      end
    end else if (!m_cyc[mdl_owner]) begin
      n_owner = -1; n_abort = 1'b0; n_waited = 0;
    end else if (!mdl_abort) begin
      if (e_stb && !s_ack) begin
        n_waited = mdl_waited + 1;
        if (n_waited == TO) begin
          n_abort = 1'b1; n_err[mdl_owner] = 1'b1; n_waited = 0;
        end
      end else begin
        n_waited = 0;
      end
    end
    @(posedge clk);
    mdl_owner = n_owner; mdl_last = n_last; mdl_waited = n_waited;
    mdl_abort = n_abort; mdl_err = n_err;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  int a_left[N];
  int a_rest[N];
  int sl_wait, sl_lat;
  int cfg_req_pct, cfg_strobes_max, cfg_lat, cfg_gap;

  task automatic set_master(input int k, input logic c, input logic s, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cyc[k] = c; m_stb[k] = s; m_we[k] = w;
    m_adr[k*AW +: AW] = a;
    m_dat[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_ack = 1'b0; s_dat = '0;
    for (int k = 0; k < N; k++) begin a_left[k] = 0; a_rest[k] = 0; end
    sl_wait = 0; sl_lat = 0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    rst = 1'b0;
  endtask

  task automatic new_beat(input int k);
    set_master(k, 1'b1, 1'b1, 1'($urandom_range(1)), $urandom, $urandom);
  endtask

  // Randomized masters react to the previous cycle's ack/err; the slave
  // answers each strobe after a chosen latency (possibly never).
  task automatic agent_drive();
    int r;
    for (int k = 0; k < N; k++) begin
      if (m_cyc[k]) begin
        if (prev_err[k]) begin
          set_master(k, 1'b0, 1'b0, 1'b0, '0, '0); a_rest[k] = cfg_gap;
        end else if (prev_ack[k]) begin
          a_left[k]--;
          if (a_left[k] == 0) begin
            set_master(k, 1'b0, 1'b0, 1'b0, '0, '0); a_rest[k] = cfg_gap;
          end else begin
            new_beat(k);
          end
        end
      end else if (a_rest[k] > 0) begin
        a_rest[k]--;
      end else if (int'($urandom_range(99)) < cfg_req_pct) begin
        a_left[k] = int'($urandom_range(cfg_strobes_max, 1));
        new_beat(k);
      end
    end
    s_dat = $urandom;
    if (mdl_stb()) begin
      if (sl_wait == 0) begin
        if (cfg_lat >= 0) sl_lat = cfg_lat;
        else begin
          r = int'($urandom_range(9));
          sl_lat = (r < 6) ? r % 4 : (r == 6) ? TO - 1 : (r == 7) ? TO : 1000;
        end
      end
      s_ack   = (sl_wait == sl_lat);
      sl_wait = s_ack ? 0 : sl_wait + 1;
    end else begin
      sl_wait = 0;
      s_ack   = ($urandom_range(9) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit m0_acked;
    mdl_reset();
    do_reset();

    // Single read by master 0, slave acks one cycle after the strobe appears.
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, '0);
    run_cycle();
    chk("t1_grant_idle", 64'(obs_grant), 64'd0);
    run_cycle();
    chk("t1_grant", 64'(obs_grant), 64'h1);
    chk("t1_adr", 64'(obs_adr), 64'h10);
    chk("t1_noack", 64'(obs_ack), 64'd0);
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    run_cycle();
    chk("t1_ack", 64'(obs_ack), 64'h1);
    chk("t1_rdata", 64'(obs_mdat), 64'hDEAD_BEEF);
    s_ack = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle();
    chk("t1_ack_once", 64'(obs_ack), 64'd0);
    run_cycle();
    chk("t1_idle", 64'(obs_busy), 64'd0);

    // All masters request back-to-back: rotation 0,1,2,3,0 with one idle cycle.
    do_reset();
    cfg_req_pct = 100; cfg_strobes_max = 1; cfg_lat = 0; cfg_gap = 1;
    obs_q.delete(); gap_q.delete();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int c = 0; c < 60 && obs_q.size() < 5; c++) begin
      agent_drive();
      run_cycle();
    end
    chk("t2_tenures", 64'(obs_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      chk($sformatf("t2_order%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
      if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(gap_q[i]), 64'd1);
    end

    // Master 2 keeps the bus for three writes while master 0 waits.
    do_reset();
    m0_acked = 1'b0;
    set_master(2, 1'b1, 1'b1, 1'b1, 32'h200, 32'h1);
    run_cycle();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0, '0);
    run_cycle();
    chk("t3_grant_first", 64'(obs_grant), 64'h4);
    for (int b = 1; b <= 3; b++) begin
      set_master(2, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(b), 32'(b));
      s_ack = 1'b1;
      run_cycle();
      chk($sformatf("t3_grant_b%0d", b), 64'(obs_grant), 64'h4);
      chk($sformatf("t3_ack_b%0d", b), 64'(obs_ack), 64'h4);
      chk($sformatf("t3_wdat_b%0d", b), 64'(obs_sdat), 64'(b));
      m0_acked |= obs_ack[0];
    end
    s_ack = 1'b0;
    set_master(2, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle();
    chk("t3_release", 64'(obs_grant), 64'h4);
    m0_acked |= obs_ack[0];
    run_cycle();
    chk("t3_deadcycle", 64'(obs_grant), 64'd0);
    m0_acked |= obs_ack[0];
    chk("t3_m0_noack", 64'(m0_acked), 64'd0);
    s_ack = 1'b1;
    run_cycle();
    chk("t3_m0_grant", 64'(obs_grant), 64'h1);
    chk("t3_m0_ack", 64'(obs_ack), 64'h1);
    s_ack = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle();

    // Dead slave: master 1 strobes, error after TO waiting cycles.
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h40, '0);
    run_cycle();
    for (int i = 1; i <= TO; i++) begin
      run_cycle();
      chk($sformatf("t4_noerr%0d", i), 64'(obs_err), 64'd0);
      chk($sformatf("t4_stb%0d", i), 64'(obs_stb), 64'd1);
    end
    run_cycle();
    chk("t4_err", 64'(obs_err), 64'h2);
    chk("t4_cyc_low", 64'(obs_cyc), 64'd0);
    run_cycle();
    chk("t4_err_once", 64'(obs_err), 64'd0);
    chk("t4_abort_busy", 64'(obs_busy), 64'd1);
    chk("t4_abort_grant", 64'(obs_grant), 64'h2);
    set_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle();
    run_cycle();
    chk("t4_idle", 64'(obs_busy), 64'd0);

    // Ack on the last allowed waiting cycle beats the watchdog.
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h44, '0);
    run_cycle();
    for (int i = 1; i < TO; i++) run_cycle();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    run_cycle();
    chk("t5_ack", 64'(obs_ack), 64'h2);
    s_ack = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle();
    chk("t5_noerr", 64'(obs_err), 64'd0);
    run_cycle();
    chk("t5_noerr2", 64'(obs_err), 64'd0);
    chk("t5_idle", 64'(obs_busy), 64'd0);

    // Reset in the middle of master 3's strobe.
    do_reset();
    set_master(3, 1'b1, 1'b1, 1'b1, 32'h300, 32'hAB);
    run_cycle();
    run_cycle();
    chk("t6_grant3", 64'(obs_grant), 64'h8);
    chk("t6_cyc3", 64'(obs_cyc), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("t6_rst_grant", 64'(grant_o), 64'd0);
    chk("t6_rst_err", 64'(m_err_o), 64'd0);
    do_reset();
    for (int k = 0; k < N; k++) set_master(k, 1'b1, 1'b1, 1'b0, 32'(k), '0);
    run_cycle();
    run_cycle();
    chk("t6_first_m0", 64'(obs_grant), 64'h1);

    // Randomized traffic with mixed latencies, timeouts and spurious acks.
    do_reset();
    cfg_req_pct = 30; cfg_strobes_max = 4; cfg_lat = -1; cfg_gap = 1;
    repeat (2000) begin
      agent_drive();
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit reached");
  end

endmodule
